mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle control unit's memory interface. It answers the read/write commands the control unit issues (MemReadWrite, address, write data) with a fixed-latency word memory.
- It exposes an explicit request/valid handshake, so later control-unit revisions can poll `busy`/`rdata_valid` instead of hard-coding wait states.
- Sits between the datapath address mux (IorD) and the IR/MDR registers.

Parameters:
- ADDR_BITS, 8, word-address width; memory depth = 2**ADDR_BITS 32-bit words.
- READ_LAT, 2, cycles from request acceptance to read data valid; legal range 1..7.
- WRITE_LAT, 1, cycles from request acceptance to write commit; legal range 1..7.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req  in  1  request strobe; sampled only when busy=0.
- mem_read_write  in  1  0 = read, 1 = write (same encoding as MemReadWrite).
- address  in  32  byte address; word index = address[ADDR_BITS+1:2].
- wdata  in  32  write data, sampled with req.
- rdata  out  32  read data, qualified by rdata_valid.
- rdata_valid  out  1  one-cycle pulse, read data ready.
- wr_done  out  1  one-cycle pulse, write committed.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle pulse, misaligned request (optional feature only; tied 0 otherwise).
- state_out  out  2  current state encoding, for debug.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is `clock`.
- Reset values:
  - state = IDLE; rdata = 0; rdata_valid = 0; wr_done = 0; err = 0; busy = 0; counter = 0.
  - Memory array is not cleared by reset.
- States and encodings: IDLE = 0, RD_WAIT = 1, WR_WAIT = 2, RESP = 3.
- Acceptance:
  - A request is accepted at edge T0 when state = IDLE and req = 1.
  - On acceptance: latch the word index, mem_read_write and wdata; load counter with the relevant latency minus 1.
  - Go to RD_WAIT or WR_WAIT according to the latched mem_read_write.
  - req while busy = 1 is ignored, not queued; it has no effect on latched values.
- RD_WAIT:
  - Counter decrements each edge.
  - At the edge where counter = 0: rdata <= mem[latched index], rdata_valid <= 1, go to RESP.
  - Net effect: rdata_valid is high in the cycle after edge T0+READ_LAT.
  - READ_LAT = 1 means RD_WAIT lasts one cycle.
- WR_WAIT:
  - Same counting.
  - At the edge where counter = 0: mem[latched index] <= latched wdata, wr_done <= 1, go to RESP.
- RESP:
  - Lasts exactly one cycle; the pulse is high there.
  - Next edge: clear the pulses and go to IDLE.
  - The next request can be accepted at edge T0+LAT+2.
  - req in RESP is ignored.
- rdata holds its last read value until the next read completes; it is never cleared except by reset.
- Address wrap: bits above ADDR_BITS+1 are ignored, so address 0x400 aliases 0x000 when ADDR_BITS = 8.
- Read-after-write to the same word returns the new value, since the write has committed before the next acceptance.
- Reset mid-operation:
  - Any in-flight write is abandoned; the array is unchanged if the commit edge has not occurred.
  - Pulses drop immediately (asynchronous).
- busy is combinational from state.

Optional Feature:
- Macro: MEM_MISALIGN_CHECK_EN.
- Defined:
  - A request with address[1:0] != 0 is accepted and goes directly to RESP with err = 1.
  - No memory access occurs; rdata_valid and wr_done stay 0; rdata is unchanged.
  - Total busy time is 1 cycle.
- Undefined:
  - address[1:0] is ignored; the access proceeds normally.
  - The err port exists and is tied 0.

Test Plan (defaults ADDR_BITS=8, READ_LAT=2, WRITE_LAT=1):
- Reset then idle:
  - Stimulus: hold reset 2 cycles, release.
  - Required: busy = 0, rdata = 0, all pulses 0, state_out = 0.
- Write then read back:
  - Stimulus: write 0xDEADBEEF to 0x10, wait for wr_done; then read 0x10.
  - Required: wr_done pulses 1 cycle after edge T0+1; rdata_valid pulses 1 cycle after edge T0+2 with rdata = 0xDEADBEEF.
- Back-to-back with held req:
  - Stimulus: req held high across a read of 0x20.
  - Required: second acceptance exactly at edge T0+4; no request is accepted while busy.
- Address wrap:
  - Stimulus: write 0x12345678 to 0x404; read 0x004.
  - Required: rdata = 0x12345678.
- Reset mid-write:
  - Stimulus: assert reset during WR_WAIT with WRITE_LAT = 3, after writing 0x0 then 0xFFFFFFFF to 0x8.
  - Required: reading 0x8 returns 0x0; busy = 0 immediately on reset.
- With MEM_MISALIGN_CHECK_EN:
  - Stimulus: write 0xAAAA5555 to 0x0 so that word 0 holds a known value, then write 0x11111111 to 0x3.
  - Required: err pulses 1 cycle after edge T0; wr_done stays 0; word 0 still reads 0xAAAA5555.

Source files
------------

// File: rtl/mem_responder_if.sv
// Command/response bundle between the multicycle control unit and the memory responder.
// The control unit is the master; the memory side is the slave.
interface mem_responder_if;
    logic        req;
    logic        mem_read_write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        wr_done;
    logic        busy;
    logic        err;
    logic [1:0]  state_out;

    modport master (
        output req, mem_read_write, address, wdata,
        input  rdata, rdata_valid, wr_done, busy, err, state_out
    );

    modport slave (
        input  req, mem_read_write, address, wdata,
        output rdata, rdata_valid, wr_done, busy, err, state_out
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory answering control-unit read/write commands over a req/busy handshake.
// Define MEM_MISALIGN_CHECK_EN to reject requests whose address[1:0] != 0 with a one-cycle err pulse.
module mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int READ_LAT  = 2,
    parameter int WRITE_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    mem_responder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam int         DEPTH   = 1 << ADDR_BITS;
    localparam logic [2:0] RD_LOAD = 3'(READ_LAT - 1);
    localparam logic [2:0] WR_LOAD = 3'(WRITE_LAT - 1);

    state_t                 state;
    logic [2:0]             counter;
    logic [ADDR_BITS-1:0]   index_q;
    logic [31:0]            wdata_q;
    logic [31:0]            rdata_q;
    logic                   rdata_valid_q;
    logic                   wr_done_q;
    logic [31:0]            mem [DEPTH];

    logic                   accept;
    logic                   commit_wr;
    logic [ADDR_BITS-1:0]   req_index;
    logic                   unused_addr_hi;

    assign accept    = (state == IDLE) && bus.req;
    assign commit_wr = (state == WR_WAIT) && (counter == 3'd0);
    assign req_index = bus.address[ADDR_BITS+1:2];

    // Upper address bits fold onto the array, so they are deliberately dropped.
    assign unused_addr_hi = ^bus.address[31:ADDR_BITS+2];

`ifdef MEM_MISALIGN_CHECK_EN
    logic err_q;
    logic misaligned;

    assign misaligned = |bus.address[1:0];
    assign bus.err    = err_q;
`else
    logic unused_addr_lo;

    assign unused_addr_lo = ^bus.address[1:0];
    assign bus.err        = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            counter       <= 3'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            wr_done_q     <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            err_q         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
`ifdef MEM_MISALIGN_CHECK_EN
                        if (misaligned) begin
                            state <= RESP;
                            err_q <= 1'b1;
                        end else
`endif
                        if (bus.mem_read_write) begin
                            state   <= WR_WAIT;
                            counter <= WR_LOAD;
                        end else begin
                            state   <= RD_WAIT;
                            counter <= RD_LOAD;
                        end
                    end
                end
                RD_WAIT: begin
                    if (counter == 3'd0) begin
                        rdata_q       <= mem[index_q];
                        rdata_valid_q <= 1'b1;
                        state         <= RESP;
                    end else begin
                        counter <= counter - 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (counter == 3'd0) begin
                        wr_done_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        counter <= counter - 3'd1;
                    end
                end
                RESP: begin
                    rdata_valid_q <= 1'b0;
                    wr_done_q     <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                    err_q         <= 1'b0;
`endif
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request payload is captured only at acceptance; req during busy cannot disturb it.
    always_ff @(posedge clock) begin
        if (accept) begin
            index_q <= req_index;
            wdata_q <= bus.wdata;
        end
    end

    // Commit is gated by the async-reset state, so a reset mid-write never reaches the array.
    always_ff @(posedge clock) begin
        if (commit_wr) begin
            mem[index_q] <= wdata_q;
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.busy        = (state != IDLE);
    assign bus.state_out   = state;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a default instance plus a WRITE_LAT=3 instance for the reset-mid-write case.
module tb_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reset_b = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wd = 32'd0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];

    mem_responder_if bus ();
    mem_responder_if bus3 ();

    assign bus.req             = req & ~sel;
    assign bus.mem_read_write  = rw;
    assign bus.address         = addr;
    assign bus.wdata           = wd;
    assign bus3.req            = req & sel;
    assign bus3.mem_read_write = rw;
    assign bus3.address        = addr;
    assign bus3.wdata          = wd;

    mem_responder #(.ADDR_BITS(8), .READ_LAT(2), .WRITE_LAT(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_responder #(.ADDR_BITS(8), .READ_LAT(2), .WRITE_LAT(3)) dut_w3 (
        .clock (clock),
        .reset (reset | reset_b),
        .bus   (bus3.slave)
    );

    always #5 clock = ~clock;

    logic [31:0] rdata_o;
    logic        rdv_o, wrd_o, busy_o, err_o;
    logic [1:0]  state_o;

    always_comb begin
        rdata_o = sel ? bus3.rdata       : bus.rdata;
        rdv_o   = sel ? bus3.rdata_valid : bus.rdata_valid;
        wrd_o   = sel ? bus3.wr_done     : bus.wr_done;
        busy_o  = sel ? bus3.busy        : bus.busy;
        err_o   = sel ? bus3.err         : bus.err;
        state_o = sel ? bus3.state_out   : bus.state_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    // Scoreboard consumer: every read-data pulse pops the oldest expected word.
    always @(negedge clock) begin
        if (!reset && (bus.rdata_valid || bus3.rdata_valid)) begin
            if (exp_q.size() == 0)
                check("sb_underflow", 32'd1, 32'd0);
            else
                check("sb_rdata", bus.rdata_valid ? bus.rdata : bus3.rdata, exp_q.pop_front());
        end
    end

    task automatic do_op(input logic s, input logic rw_i, input logic [31:0] a,
                         input logic [31:0] d, input string tag);
        int   lat;
        int   n;
        logic seen;
        lat = rw_i ? (s ? 3 : 1) : 2;
        @(negedge clock);
        sel = s;
        #1;
        check({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        req  = 1'b1;
        rw   = rw_i;
        addr = a;
        wd   = d;
        if (!rw_i) exp_q.push_back(s ? model1[widx(a)] : model0[widx(a)]);
        @(posedge clock);
        @(negedge clock);
        req  = 1'b0;
        n    = 1;
        seen = 1'b0;
        while (n <= 20 && !seen) begin
            if (rw_i ? wrd_o : rdv_o) seen = 1'b1;
            else begin
                @(negedge clock);
                n++;
            end
        end
        check({tag, "_lat"}, 32'(n), 32'(lat + 1));
        if (seen) begin
            check({tag, "_other"}, {31'd0, rw_i ? rdv_o : wrd_o}, 32'd0);
            check({tag, "_err"}, {31'd0, err_o}, 32'd0);
            if (rw_i) begin
                if (s) model1[widx(a)] = d;
                else   model0[widx(a)] = d;
            end
            @(negedge clock);
            check({tag, "_width"}, {31'd0, rw_i ? wrd_o : rdv_o}, 32'd0);
            check({tag, "_free"}, {31'd0, busy_o}, 32'd0);
        end
    endtask

    logic [1:0] st_tab  [8] = '{2'd1, 2'd1, 2'd3, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
    logic       rdv_tab [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_busy",  {31'd0, bus.busy},        32'd0);
        check("rst_rdata", bus.rdata,                32'd0);
        check("rst_rdv",   {31'd0, bus.rdata_valid}, 32'd0);
        check("rst_wrd",   {31'd0, bus.wr_done},     32'd0);
        check("rst_err",   {31'd0, bus.err},         32'd0);
        check("rst_state", {30'd0, bus.state_out},   32'd0);

        // Write then read back
        do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
        do_op(1'b0, 1'b0, 32'h10, 32'h0, "rd10");
        check("rd10_data", rdata_o, 32'hDEADBEEF);
        @(negedge clock);
        check("rd10_hold", rdata_o, 32'hDEADBEEF);

        // Held req: the second acceptance lands exactly four edges after the first
        do_op(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, "wr20");
        do_op(1'b0, 1'b1, 32'h30, 32'h0BADC0DE, "wr30");
        @(negedge clock);
        sel  = 1'b0;
        req  = 1'b1;
        rw   = 1'b0;
        addr = 32'h20;
        exp_q.push_back(32'hCAFEF00D);
        exp_q.push_back(32'hCAFEF00D);
        @(posedge clock);
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            check($sformatf("held_state%0d", n + 1), {30'd0, state_o}, {30'd0, st_tab[n]});
            check($sformatf("held_rdv%0d", n + 1), {31'd0, rdv_o}, {31'd0, rdv_tab[n]});
            if (n == 0) begin
                addr = 32'h30;
                rw   = 1'b1;
                wd   = 32'h00000055;
            end
            if (n == 2) begin
                addr = 32'h20;
                rw   = 1'b0;
            end
            if (n == 4) req = 1'b0;
        end
        do_op(1'b0, 1'b0, 32'h30, 32'h0, "rd30");
        check("rd30_data", rdata_o, 32'h0BADC0DE);

        // Address wrap
        do_op(1'b0, 1'b1, 32'h404, 32'h12345678, "wr404");
        do_op(1'b0, 1'b0, 32'h004, 32'h0, "rd004");
        check("wrap_data", rdata_o, 32'h12345678);

        // Reset mid-write on the WRITE_LAT=3 instance
        do_op(1'b1, 1'b1, 32'h8, 32'h0, "w3_wr8");
        @(negedge clock);
        sel  = 1'b1;
        req  = 1'b1;
        rw   = 1'b1;
        addr = 32'h8;
        wd   = 32'hFFFFFFFF;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        check("mid_state", {30'd0, state_o}, 32'd2);
        #1 reset_b = 1'b1;
        #1;
        check("mid_busy",  {31'd0, busy_o}, 32'd0);
        check("mid_st0",   {30'd0, state_o}, 32'd0);
        check("mid_wrd",   {31'd0, wrd_o}, 32'd0);
        @(negedge clock);
        reset_b = 1'b0;
        @(negedge clock);
        do_op(1'b1, 1'b0, 32'h8, 32'h0, "w3_rd8");
        check("mid_data", rdata_o, 32'h0);

        // Misaligned request
        do_op(1'b0, 1'b1, 32'h0, 32'hAAAA5555, "wr0");
`ifdef MEM_MISALIGN_CHECK_EN
        @(negedge clock);
        sel  = 1'b0;
        req  = 1'b1;
        rw   = 1'b1;
        addr = 32'h3;
        wd   = 32'h11111111;
        @(posedge clock);
        @(negedge clock);
        req = 1'b0;
        check("mis_err",   {31'd0, err_o}, 32'd1);
        check("mis_state", {30'd0, state_o}, 32'd3);
        check("mis_wrd",   {31'd0, wrd_o}, 32'd0);
        check("mis_rdv",   {31'd0, rdv_o}, 32'd0);
        @(negedge clock);
        check("mis_err_w", {31'd0, err_o}, 32'd0);
        check("mis_busy",  {31'd0, busy_o}, 32'd0);
        do_op(1'b0, 1'b0, 32'h0, 32'h0, "mis_rd0");
        check("mis_data", rdata_o, 32'hAAAA5555);
`else
        do_op(1'b0, 1'b1, 32'h3, 32'h11111111, "mis_wr3");
        do_op(1'b0, 1'b0, 32'h0, 32'h0, "mis_rd0");
        check("mis_data", rdata_o, 32'h11111111);
`endif

        repeat (2) @(negedge clock);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
